fp_mult_pipe_driver: RTL
========================

# fp_mult_pipe_driver

Sequencing front-end for the pipelined fixed-point multiplier (go/done protocol, 3-cycle latency, operands sampled while `go` is high). It accepts operand pairs on a valid/ready stream, holds operands and `go` stable until the multiplier raises `done`, and captures the product into a one-entry result register with a valid/ready output. It enforces the mandatory idle gap between operations, and optionally runs a watchdog on `done`.

## Interface
Parameters:
- `WIDTH`, 4, operand and result width; must match the multiplier's `WIDTH`.
- `TIMEOUT`, 15, maximum cycles in ISSUE before the watchdog fires; legal range 4..255. Only used when the watchdog is compiled in.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept an operand pair.
- `in_left`  in  WIDTH  left operand.
- `in_right`  in  WIDTH  right operand.
- `mult_go`  out  1  go to the multiplier.
- `mult_left`  out  WIDTH  registered left operand to the multiplier.
- `mult_right`  out  WIDTH  registered right operand to the multiplier.
- `mult_out`  in  WIDTH  product from the multiplier.
- `mult_done`  in  1  done from the multiplier.
- `res_valid`  out  1  result register full.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  WIDTH  captured product.
- `res_err`  out  1  result produced by a watchdog timeout; qualified by `res_valid`.

## Operation
- FSM states: IDLE, ISSUE, HOLD. Reset state is IDLE.
- All outputs reset to 0: `in_ready`, `mult_go`, `mult_left`, `mult_right`, `res_valid`, `res_data`, `res_err`, and the watchdog counter.
- IDLE:
  - `in_ready=1`.
  - On `in_valid & in_ready`: latch `in_left`/`in_right` into `mult_left`/`mult_right`, clear the watchdog counter, go to ISSUE.
- ISSUE:
  - `mult_go=1`; `mult_left`/`mult_right` stay frozen; `in_ready=0`.
  - On `mult_done=1`: capture `mult_out` into `res_data`, set `res_err=0` and `res_valid=1`, go to HOLD.
  - `mult_done` is ignored in IDLE and HOLD.
- HOLD:
  - `mult_go=0`, `in_ready=0`.
  - On `res_ready=1`: clear `res_valid`, go to IDLE.
  - HOLD always lasts at least one cycle. Together with the IDLE accept cycle, `mult_go` is therefore low for at least 2 cycles between operations, which clears the multiplier's done pipeline.
- Operand registers are cleared to 0 when leaving ISSUE, so the multiplier sees zeros while idle.
- `in_ready` is a registered function of state only. It does not depend combinationally on `in_valid` or `res_ready`.
- Arithmetic is not performed in this block. `res_data` is `mult_out` bit-for-bit, with signedness as configured in the multiplier.

## Timing
- Accept handshake in cycle 0 → `mult_go` high in cycles 1..4 → `mult_done` seen in cycle 4 → `res_valid=1` from cycle 5.
- Fixed latency from accept to `res_valid`: 5 cycles with the 3-cycle multiplier.
- With `res_ready` tied high:
  - `res_valid` is high in cycle 5; HOLD→IDLE at the end of cycle 5.
  - `in_ready` is high in cycle 6, so the next accept is possible in cycle 6.
  - Sustained throughput is 1 result per 6 cycles.
- Backpressure: while `res_ready=0`, `res_valid` and `res_data` hold indefinitely and `in_ready` stays 0.
- `in_valid` arriving during ISSUE or HOLD is not accepted; the upstream holds it.
- Reset asserted in any state, including mid-ISSUE: next cycle is IDLE, all outputs are 0, and any in-flight product is discarded. A `mult_done` seen in the reset cycle is ignored.

## Configuration
- `FP_MULT_DRV_WATCHDOG_EN` defined:
  - An 8-bit counter increments each ISSUE cycle.
  - If it reaches `TIMEOUT` with `mult_done` still 0, go to HOLD with `res_data=0`, `res_err=1`, `res_valid=1`, and drop `mult_go`.
  - If `mult_done` and the timeout occur in the same cycle, `mult_done` wins: the result is normal and `res_err=0`.
- Not defined: no counter is built, `res_err` is tied to 0, and ISSUE waits for `mult_done` forever.

## Test plan
- Signed, `WIDTH=4`: accept `in_left=3`, `in_right=-2` (4'hE) in cycle 0, with the multiplier attached → `res_valid` in cycle 5, `res_data=4'hA` (-6), `res_err=0`.
- Back-to-back: `in_valid` held high with pairs (2,3) then (-1,-1) and `res_ready=1` → results 6 in cycle 5 and 1 in cycle 11; `mult_go` low for ≥2 cycles between operations.
- Backpressure: `res_ready=0` for 10 cycles after the first result → `res_valid` and `res_data` stable, `in_ready=0`, no `mult_go`; release → IDLE the next cycle.
- Reset in cycle 2 of ISSUE → cycle 3 all outputs are 0, state IDLE; a new accept then yields the correct product 5 cycles later.
- Watchdog on (`TIMEOUT=6`), `mult_done` stubbed to 0 → `res_valid=1`, `res_err=1`, `res_data=0` after 6 ISSUE cycles. Stub `mult_done` pulsed in the 6th ISSUE cycle → normal result with `res_err=0`.
- Watchdog off, `mult_done` stubbed to 0 for 300 cycles → remains in ISSUE with `mult_go=1`; `res_err` never 1.

Source files
------------

// File: rtl/fp_mult_pipe_driver.sv
// fp_mult_pipe_driver
// Sequencing front-end for a pipelined go/done fixed-point multiplier.
// It accepts one operand pair on a valid/ready stream and holds the operands
// and mult_go stable until mult_done. It then captures the product into a
// one-entry result register that has a valid/ready output. A HOLD state of at
// least one cycle, plus the IDLE accept cycle, keeps mult_go low for at least
// two cycles between operations.
//
// Optional feature: define FP_MULT_DRV_WATCHDOG_EN to build a watchdog on
// mult_done. If mult_done does not arrive within TIMEOUT ISSUE cycles, the
// watchdog emits an error result (res_err=1, res_data=0).
module fp_mult_pipe_driver #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_left,
  input  logic [WIDTH-1:0] in_right,
  output logic             mult_go,
  output logic [WIDTH-1:0] mult_left,
  output logic [WIDTH-1:0] mult_right,
  input  logic [WIDTH-1:0] mult_out,
  input  logic             mult_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD
  } state_e;

  // Reject an out-of-range watchdog limit at elaboration time.
  if ((TIMEOUT < 4) || (TIMEOUT > 255)) begin : g_timeout_range
    $error("fp_mult_pipe_driver: TIMEOUT must be in 4..255");
  end

  state_e           state_q;
  logic             in_ready_q;
  logic             mult_go_q;
  logic [WIDTH-1:0] left_q;
  logic [WIDTH-1:0] right_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_err_q;

  logic accept;
  logic timeout_hit;

  // in_ready_q is only ever set while in IDLE, so this is the full handshake.
  assign accept = (state_q == S_IDLE) && in_valid && in_ready_q;

`ifdef FP_MULT_DRV_WATCHDOG_EN
  localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);

  logic [7:0] wd_cnt_q;

  // The counter counts the ISSUE cycles of the current operation.
  // It is cleared on the accept cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q <= '0;
    end else if (accept) begin
      wd_cnt_q <= '0;
    end else if (state_q == S_ISSUE) begin
      wd_cnt_q <= wd_cnt_q + 8'd1;
    end
  end

  // True in the TIMEOUT-th ISSUE cycle: the counter reaches TIMEOUT on this edge.
  assign timeout_hit = (wd_cnt_q == WdLast);
`else
  assign timeout_hit = 1'b0;
`endif

  // Control FSM. Every output is a register that the state transitions update.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: state and outputs use non-blocking assignments, so every branch
      // below reads values from before the edge. This holds however the
      // statements are ordered.
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      mult_go_q   <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            left_q     <= in_left;
            right_q    <= in_right;
            mult_go_q  <= 1'b1;
            in_ready_q <= 1'b0;
            state_q    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // mult_done takes priority over a timeout in the same cycle.
          if (mult_done) begin
            res_data_q  <= mult_out;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b1;
            mult_go_q   <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            state_q     <= S_HOLD;
          end else if (timeout_hit) begin
            res_data_q  <= '0;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            mult_go_q   <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            state_q     <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b0;
          mult_go_q   <= 1'b0;
          left_q      <= '0;
          right_q     <= '0;
          res_valid_q <= 1'b0;
          res_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign mult_go    = mult_go_q;
  assign mult_left  = left_q;
  assign mult_right = right_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_err    = res_err_q;

endmodule
